// File: rtl/calc_cmd_sched.sv
// Command scheduler between the keypad decoder and the calculator core.
// Queues keypad codes and issues each to the core as a one-cycle pulse, recovering from core errors.
module calc_cmd_sched #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [3:0]  IDLE_CODE   = 4'hD,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned RST_CYCLES  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    output logic                     key_ready,
    input  logic [1:0]               calc_status,
    output logic [3:0]               calc_cmd,
    output logic                     calc_rst,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     err_seen
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + RST_CYCLES) + 1;

    localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] STAT_ERR   = 2'b00;
    localparam logic [1:0] STAT_READY = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_RECOVER    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q, err_q;
    logic [3:0]         cmd_q, cmd_d;
    logic               crst_q, crst_d;
    logic               live_q;

    logic full_s, empty_s, err_s, pop_s, push_try_s, push_s, drop_s;

    assign full_s     = (count_q == CNT_FULL);
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    assign err_s      = (calc_status == STAT_ERR) && (state_q != ST_RECOVER);
    assign pop_s      = (state_q == ST_IDLE) && !empty_s && (calc_status == STAT_READY);
    // A push landing in the error cycle is discarded together with the flushed queue.
    assign push_try_s = key_valid && live_q && (state_q != ST_RECOVER) && !err_s;
    assign push_s     = push_try_s && (!full_s || pop_s);
    assign drop_s     = push_try_s && full_s && !pop_s;

    assign key_ready  = live_q && !full_s && (state_q != ST_RECOVER);
    assign calc_cmd   = cmd_q;
    assign calc_rst   = crst_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign err_seen   = err_q;

    // State register and shared ack/recovery timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= {TMR_W{1'b0}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic; a core error pre-empts every state but RECOVER
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (err_s) begin
            state_d = ST_RECOVER;
            timer_d = {TMR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT_ACK;
                    timer_d = {TMR_W{1'b0}};
                end
                ST_WAIT_ACK: begin
                    if (calc_status != STAT_READY) begin
                        state_d = ST_WAIT_READY;
                    end else if (timer_q == ACK_LAST) begin
                        state_d = ST_IDLE;
                        timer_d = {TMR_W{1'b0}};
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_WAIT_READY: begin
                    if (calc_status == STAT_READY) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end
                ST_RECOVER: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_IDLE;
                        timer_d = {TMR_W{1'b0}};
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the core sees clean registered levels
    always_comb begin
        cmd_d  = IDLE_CODE;
        crst_d = 1'b0;
        if (state_d == ST_ISSUE) begin
            cmd_d = mem_q[rd_ptr_q];
        end else begin
            cmd_d = IDLE_CODE;
        end
        if ((state_d == ST_RECOVER) && (timer_d < RST_LAST)) begin
            crst_d = 1'b1;
        end else begin
            crst_d = 1'b0;
        end
    end

    // Registered core-facing outputs and the post-reset enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_q  <= IDLE_CODE;
            crst_q <= 1'b0;
            live_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            crst_q <= crst_d;
            live_q <= 1'b1;
        end
    end

    // Circular FIFO storage, pointers, occupancy and sticky flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (err_s) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            err_q    <= 1'b1;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= key_code;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched: a small reactive core model plus hand-derived pulse orders and timings.
module tb_calc_cmd_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [1:0] calc_status;
    logic [3:0] calc_cmd;
    logic       calc_rst;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       err_seen;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] pulses [$];
    int         pulse_cyc [$];
    logic       prev_pulse;
    logic       have_pulse;
    int         last_cyc;
    int         busy_left;
    logic       core_en;

    calc_cmd_sched #(
        .DEPTH(8), .IDLE_CODE(4'hD), .ACK_TIMEOUT(4), .RST_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .calc_status(calc_status), .calc_cmd(calc_cmd),
        .calc_rst(calc_rst), .fifo_count(fifo_count), .overflow(overflow),
        .err_seen(err_seen)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pulses.delete();
        pulse_cyc.delete();
        prev_pulse = 1'b0;
        have_pulse = 1'b0;
        busy_left  = 0;
    endtask

    // One clock: sample after the edge, log pulses, and let the core model react.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (calc_cmd != 4'hD) begin
            check_eq("pulse_width", 32'(prev_pulse), 32'd0);
            if (have_pulse) check_eq("spacing", ((cyc - last_cyc) >= 3) ? 32'd1 : 32'd0, 32'd1);
            pulses.push_back(calc_cmd);
            pulse_cyc.push_back(cyc);
            last_cyc   = cyc;
            have_pulse = 1'b1;
            prev_pulse = 1'b1;
            if (core_en && calc_cmd <= 4'd9) busy_left = 8;
        end else begin
            prev_pulse = 1'b0;
        end
        if (core_en) begin
            if (busy_left > 0) begin
                calc_status = 2'b11;
                busy_left--;
            end else begin
                calc_status = 2'b10;
            end
        end
    endtask

    task automatic push_step(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        calc_status = 2'b01;
        core_en     = 1'b0;
        clear_mon();

        // Reset values
        #12;
        check_eq("rst_cmd",   32'(calc_cmd),   32'hD);
        check_eq("rst_crst",  32'(calc_rst),   32'd0);
        check_eq("rst_ready", 32'(key_ready),  32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ovf",   32'(overflow),   32'd0);
        check_eq("rst_err",   32'(err_seen),   32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        check_eq("ready_after_rst", 32'(key_ready), 32'd1);

        // Single issue of digit 7
        core_en = 1'b1;
        calc_status = 2'b10;
        clear_mon();
        push_step(4'd7);
        check_eq("single_count1", 32'(fifo_count), 32'd1);
        check_eq("single_cmd_pre", 32'(calc_cmd), 32'hD);
        step();
        check_eq("single_cmd7",   32'(calc_cmd),   32'd7);
        check_eq("single_count0", 32'(fifo_count), 32'd0);
        step();
        check_eq("single_cmd_post", 32'(calc_cmd), 32'hD);
        for (int i = 0; i < 15; i++) step();
        check_eq("single_npulse", 32'(pulses.size()), 32'd1);

        // Burst 1, 2, op 10, 3
        clear_mon();
        push_step(4'd1);
        push_step(4'd2);
        push_step(4'd10);
        push_step(4'd3);
        for (int i = 0; i < 45; i++) step();
        check_eq("burst_npulse", 32'(pulses.size()), 32'd4);
        if (pulses.size() == 4) begin
            check_eq("burst_o0", 32'(pulses[0]), 32'd1);
            check_eq("burst_o1", 32'(pulses[1]), 32'd2);
            check_eq("burst_o2", 32'(pulses[2]), 32'd10);
            check_eq("burst_o3", 32'(pulses[3]), 32'd3);
            check_eq("burst_gap_digit", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd10);
            check_eq("burst_gap_op",    32'(pulse_cyc[3] - pulse_cyc[2]), 32'd6);
        end

        // Overflow: core busy, nine pushes into eight entries
        core_en = 1'b0;
        calc_status = 2'b01;
        clear_mon();
        for (int i = 1; i <= 8; i++) push_step(4'(i));
        check_eq("full_count", 32'(fifo_count), 32'd8);
        check_eq("full_ready", 32'(key_ready),  32'd0);
        check_eq("full_ovf0",  32'(overflow),   32'd0);
        push_step(4'hF);
        check_eq("ovf_count", 32'(fifo_count), 32'd8);
        check_eq("ovf_flag",  32'(overflow),   32'd1);

        // Simultaneous push and pop at full
        calc_status = 2'b10;
        core_en = 1'b1;
        push_step(4'd9);
        check_eq("pushpop_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 95; i++) step();
        check_eq("drain_npulse", 32'(pulses.size()), 32'd9);
        if (pulses.size() == 9) begin
            for (int i = 0; i < 9; i++) check_eq("drain_order", 32'(pulses[i]), 32'(i + 1));
        end
        check_eq("drain_count", 32'(fifo_count), 32'd0);

        // Error recovery with five queued codes
        core_en = 1'b0;
        calc_status = 2'b01;
        clear_mon();
        push_step(4'd2);
        push_step(4'd4);
        push_step(4'd6);
        push_step(4'd8);
        push_step(4'd0);
        check_eq("err_pre_count", 32'(fifo_count), 32'd5);
        calc_status = 2'b00;
        step();
        check_eq("err_seen",   32'(err_seen),   32'd1);
        check_eq("err_flush",  32'(fifo_count), 32'd0);
        check_eq("err_crst1",  32'(calc_rst),   32'd1);
        check_eq("err_ready1", 32'(key_ready),  32'd0);
        calc_status = 2'b10;
        push_step(4'd4);
        check_eq("err_crst2",  32'(calc_rst),   32'd1);
        check_eq("err_ready2", 32'(key_ready),  32'd0);
        check_eq("err_nopush", 32'(fifo_count), 32'd0);
        step();
        check_eq("err_crst3",  32'(calc_rst),   32'd0);
        step();
        check_eq("err_idle_ready", 32'(key_ready),  32'd1);
        check_eq("err_idle_count", 32'(fifo_count), 32'd0);
        check_eq("err_npulse",     32'(pulses.size()), 32'd0);
        check_eq("ovf_sticky",     32'(overflow),   32'd1);

        // Reset asserted while waiting for the core to become ready
        core_en = 1'b1;
        clear_mon();
        push_step(4'd5);
        push_step(4'd6);
        push_step(4'd7);
        step();
        step();
        check_eq("mid_count", 32'(fifo_count), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_cmd",   32'(calc_cmd),   32'hD);
        check_eq("mid_crst",  32'(calc_rst),   32'd0);
        check_eq("mid_ready", 32'(key_ready),  32'd0);
        check_eq("mid_count0", 32'(fifo_count), 32'd0);
        check_eq("mid_ovf",   32'(overflow),   32'd0);
        check_eq("mid_err",   32'(err_seen),   32'd0);
        clear_mon();
        calc_status = 2'b10;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("post_count",  32'(fifo_count), 32'd0);
        check_eq("post_npulse", 32'(pulses.size()), 32'd0);
        check_eq("post_ready",  32'(key_ready),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
